// File: rtl/sh7604_ubc_match_pkg.sv
// Shared field positions, types and helpers for the SH7604 UBC break-condition engine.
package sh7604_ubc_match_pkg;

    // Positions of the 2-bit fields inside BBRA/BBRB.
    localparam int unsigned BBR_CP_LSB = 6;
    localparam int unsigned BBR_ID_LSB = 4;
    localparam int unsigned BBR_RW_LSB = 2;
    localparam int unsigned BBR_SZ_LSB = 0;

    localparam int unsigned BRCR_PCBA = 10;
    localparam int unsigned BRCR_SEQ  = 4;
    localparam int unsigned BRCR_DBEB = 3;
    localparam int unsigned BRCR_PCBB = 2;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StASeen = 1'b1
    } seq_state_e;

    // Stage-1 snapshot: hits plus the attributes and controls the cycle completes with.
    typedef struct packed {
        logic       hit_a;
        logic       hit_b;
        logic       cpu;
        logic       ifetch;
        logic [1:0] sz;
        logic       pcba;
        logic       pcbb;
        logic       dbeb;
        logic       seq;
    } stage1_t;

    function automatic logic [31:0] sz_lane_mask(input logic [1:0] sz);
        logic [31:0] mask;
        case (sz)
            2'b01:   mask = 32'h0000_00FF;
            2'b10:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sh7604_ubc_chan_cmp.sv
// Combinational address and bus-cycle-condition comparator for one UBC break channel.
module sh7604_ubc_chan_cmp
    import sh7604_ubc_match_pkg::*;
(
    input  logic [31:0] i_bus_a,
    input  logic [31:0] i_bar,
    input  logic [31:0] i_bamr,
    input  logic [7:0]  i_bbr,
    input  logic        i_cpu,
    input  logic        i_ifetch,
    input  logic        i_we,
    input  logic [1:0]  i_sz,
    output logic        o_hit
);

    logic [1:0] w_cp;
    logic [1:0] w_id;
    logic [1:0] w_rw;
    logic [1:0] w_sz;
    logic       w_addr_hit;
    logic       w_cp_hit;
    logic       w_id_hit;
    logic       w_rw_hit;
    logic       w_sz_hit;

    assign w_cp = i_bbr[BBR_CP_LSB +: 2];
    assign w_id = i_bbr[BBR_ID_LSB +: 2];
    assign w_rw = i_bbr[BBR_RW_LSB +: 2];
    assign w_sz = i_bbr[BBR_SZ_LSB +: 2];

    assign w_addr_hit = ((i_bus_a ^ i_bar) & ~i_bamr) == 32'd0;

    // A 00 field in CP, ID or RW can never be satisfied, which disables the channel.
    assign w_cp_hit = |(w_cp & {~i_cpu, i_cpu});
    assign w_id_hit = |(w_id & {~i_ifetch, i_ifetch});
    assign w_rw_hit = |(w_rw & {i_we, ~i_we});
    assign w_sz_hit = (w_sz == 2'b00) || (w_sz == i_sz);

    assign o_hit = w_addr_hit & w_cp_hit & w_id_hit & w_rw_hit & w_sz_hit;

endmodule

// File: rtl/sh7604_ubc_match.sv
// SH7604 UBC break-condition engine: two-stage bus compare, post-execution parking, A-then-B
// sequencing and the user-break IRQ. Define SH7604_UBC_DATA_CMP_EN for channel B data compare.
module sh7604_ubc_match
    import sh7604_ubc_match_pkg::*;
#(
    parameter int unsigned DISABLE = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        EN,
    input  logic [31:0] BARA,
    input  logic [31:0] BAMRA,
    input  logic [31:0] BARB,
    input  logic [31:0] BAMRB,
    input  logic [15:0] BBRA,
    input  logic [15:0] BBRB,
    input  logic [31:0] BDRB,
    input  logic [31:0] BDMRB,
    input  logic [15:0] BRCR,
    input  logic [31:0] BUS_A,
    input  logic        BUS_START,
    input  logic        BUS_CPU,
    input  logic        BUS_IF,
    input  logic        BUS_WE,
    input  logic [1:0]  BUS_SZ,
    input  logic [31:0] BUS_D,
    input  logic        BUS_DONE,
    input  logic        INSTR_DONE,
    input  logic        IRQ_ACK,
    output logic [3:0]  CMF_SET,
    output logic        IRQ
);

    generate
        if (DISABLE != 0) begin : g_off
            logic w_unused;
            assign w_unused = ^{CLK, RST, CE_R, EN, BARA, BAMRA, BARB, BAMRB, BBRA, BBRB,
                                BDRB, BDMRB, BRCR, BUS_A, BUS_START, BUS_CPU, BUS_IF, BUS_WE,
                                BUS_SZ, BUS_D, BUS_DONE, INSTR_DONE, IRQ_ACK};
            assign CMF_SET = 4'b0000;
            assign IRQ     = 1'b0;
        end else begin : g_on
            logic       w_step;
            logic       w_done;
            logic       w_hit_a;
            logic       w_hit_b;
            logic       w_data_ok;
            logic       w_b_ok;
            logic       w_conf_a;
            logic       w_conf_b;
            logic       w_park_a;
            logic       w_park_b;
            logic       w_imm_a;
            logic       w_imm_b;
            logic       w_pfire_a;
            logic       w_pfire_b;
            logic [1:0] w_flag_a;
            logic [1:0] w_flag_b;
            logic       w_ev_a;
            logic       w_ev_b;
            logic [3:0] w_cmf;
            logic       w_fire;
            seq_state_e w_state_d;
            stage1_t    w_s1_d;
            logic       w_unused;

            stage1_t    r_s1;
            logic       r_busy;
            logic       r_post_a;
            logic       r_post_b;
            logic       r_post_cpu_a;
            logic       r_post_cpu_b;
            seq_state_e r_state;
            logic [3:0] r_cmf;
            logic       r_irq;

            sh7604_ubc_chan_cmp u_cmp_a (
                .i_bus_a  (BUS_A),
                .i_bar    (BARA),
                .i_bamr   (BAMRA),
                .i_bbr    (BBRA[7:0]),
                .i_cpu    (BUS_CPU),
                .i_ifetch (BUS_IF),
                .i_we     (BUS_WE),
                .i_sz     (BUS_SZ),
                .o_hit    (w_hit_a)
            );

            sh7604_ubc_chan_cmp u_cmp_b (
                .i_bus_a  (BUS_A),
                .i_bar    (BARB),
                .i_bamr   (BAMRB),
                .i_bbr    (BBRB[7:0]),
                .i_cpu    (BUS_CPU),
                .i_ifetch (BUS_IF),
                .i_we     (BUS_WE),
                .i_sz     (BUS_SZ),
                .o_hit    (w_hit_b)
            );

            assign w_step = CE_R & EN;

            always_comb begin
                w_s1_d        = '0;
                w_s1_d.hit_a  = w_hit_a;
                w_s1_d.hit_b  = w_hit_b;
                w_s1_d.cpu    = BUS_CPU;
                w_s1_d.ifetch = BUS_IF;
                w_s1_d.sz     = BUS_SZ;
                w_s1_d.pcba   = BRCR[BRCR_PCBA];
                w_s1_d.pcbb   = BRCR[BRCR_PCBB];
                w_s1_d.seq    = BRCR[BRCR_SEQ];
`ifdef SH7604_UBC_DATA_CMP_EN
                w_s1_d.dbeb   = BRCR[BRCR_DBEB];
`endif
            end

`ifdef SH7604_UBC_DATA_CMP_EN
            assign w_data_ok = ((BUS_D ^ BDRB) & ~BDMRB & sz_lane_mask(r_s1.sz)) == 32'd0;
            assign w_unused  = ^{BBRA[15:8], BBRB[15:8], BRCR[15:11], BRCR[9:5], BRCR[1:0]};
`else
            assign w_data_ok = 1'b1;
            assign w_unused  = ^{BBRA[15:8], BBRB[15:8], BRCR[15:11], BRCR[9:5], BRCR[3],
                                 BRCR[1:0], BDRB, BDMRB, BUS_D, r_s1.sz, r_s1.dbeb};
`endif

            // Stage 2: only the single in-flight cycle can complete.
            assign w_done   = w_step & BUS_DONE & r_busy;
            assign w_b_ok   = r_s1.hit_b & (r_s1.ifetch | ~r_s1.dbeb | w_data_ok);
            assign w_conf_a = w_done & r_s1.hit_a;
            assign w_conf_b = w_done & w_b_ok;
            assign w_park_a = w_conf_a & r_s1.ifetch & r_s1.pcba;
            assign w_park_b = w_conf_b & r_s1.ifetch & r_s1.pcbb;
            assign w_imm_a  = w_conf_a & ~w_park_a;
            assign w_imm_b  = w_conf_b & ~w_park_b;

            assign w_pfire_a = w_step & INSTR_DONE & r_post_a;
            assign w_pfire_b = w_step & INSTR_DONE & r_post_b;

            // {CPU, DMA} flag per channel from either the immediate or the parked source.
            assign w_flag_a = {(w_imm_a & r_s1.cpu) | (w_pfire_a & r_post_cpu_a),
                               (w_imm_a & ~r_s1.cpu) | (w_pfire_a & ~r_post_cpu_a)};
            assign w_flag_b = {(w_imm_b & r_s1.cpu) | (w_pfire_b & r_post_cpu_b),
                               (w_imm_b & ~r_s1.cpu) | (w_pfire_b & ~r_post_cpu_b)};
            assign w_ev_a   = |w_flag_a;
            assign w_ev_b   = |w_flag_b;

            always_comb begin
                w_state_d = r_state;
                w_cmf     = 4'b0000;
                w_fire    = 1'b0;
                if (r_s1.seq) begin
                    w_cmf[3:2] = w_flag_a;
                    if (w_ev_b && (r_state == StASeen)) begin
                        w_cmf[1:0] = w_flag_b;
                        w_fire     = 1'b1;
                        w_state_d  = StIdle;
                    end else if (w_ev_a) begin
                        w_state_d  = StASeen;
                    end
                end else begin
                    w_cmf     = {w_flag_a, w_flag_b};
                    w_fire    = w_ev_a | w_ev_b;
                    w_state_d = StIdle;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_s1         <= '0;
                    r_busy       <= 1'b0;
                    r_post_a     <= 1'b0;
                    r_post_b     <= 1'b0;
                    r_post_cpu_a <= 1'b0;
                    r_post_cpu_b <= 1'b0;
                    r_state      <= StIdle;
                    r_cmf        <= 4'b0000;
                    r_irq        <= 1'b0;
                end else begin
                    r_cmf <= 4'b0000;
                    if (w_step) begin
                        // A start while a cycle is outstanding is dropped.
                        if (BUS_START && !r_busy) begin
                            r_busy <= 1'b1;
                            r_s1   <= w_s1_d;
                        end else if (w_done) begin
                            r_busy <= 1'b0;
                        end
                        if (w_park_a) begin
                            r_post_a     <= 1'b1;
                            r_post_cpu_a <= r_s1.cpu;
                        end else if (w_pfire_a) begin
                            r_post_a     <= 1'b0;
                        end
                        if (w_park_b) begin
                            r_post_b     <= 1'b1;
                            r_post_cpu_b <= r_s1.cpu;
                        end else if (w_pfire_b) begin
                            r_post_b     <= 1'b0;
                        end
                        r_state <= w_state_d;
                        r_cmf   <= w_cmf;
                        r_irq   <= w_fire | (r_irq & ~IRQ_ACK);
                    end
                end
            end

            assign CMF_SET = r_cmf;
            assign IRQ     = r_irq;
        end
    endgenerate

endmodule
